// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: arbitrates the single piezo buzzer between key-click,
// door chime and the repeating cook-complete alarm. Requests are captured
// into one-cycle / pending registers first, so the FSM always acts one cycle
// after a request is sampled. All outputs come straight from flops.
module buzzer_scheduler #(
  parameter int unsigned TICKS_PER_MS  = 100_000,
  parameter int unsigned CLICK_MS      = 50,
  parameter int unsigned DOOR_MS       = 120,
  parameter int unsigned ALARM_ON_MS   = 300,
  parameter int unsigned ALARM_OFF_MS  = 200,
  parameter int unsigned ALARM_REPEATS = 3,
  parameter int unsigned CLICK_DIV     = 50_000,
  parameter int unsigned DOOR_DIV      = 100_000,
  parameter int unsigned ALARM_DIV     = 25_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       click_req,
  input  logic       door_req,
  input  logic       alarm_req,
  input  logic       alarm_cancel,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_src,
  output logic       alarm_done
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CLICK_T = CLICK_MS * TICKS_PER_MS;
  localparam int unsigned DOOR_T  = DOOR_MS * TICKS_PER_MS;
  localparam int unsigned ON_T    = ALARM_ON_MS * TICKS_PER_MS;
  localparam int unsigned OFF_T   = ALARM_OFF_MS * TICKS_PER_MS;
  localparam int unsigned DUR_MAX = max2(max2(CLICK_T, DOOR_T), max2(ON_T, OFF_T));
  localparam int unsigned DW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int unsigned DIV_MAX = max2(max2(CLICK_DIV, DOOR_DIV), ALARM_DIV);
  localparam int unsigned TW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLICK     = 3'd1,
    S_DOOR      = 3'd2,
    S_ALARM_ON  = 3'd3,
    S_ALARM_OFF = 3'd4
  } state_t;

  // States in which the tone bit may reach the pin.
  function automatic logic is_sounding(input state_t s);
    return (s == S_CLICK) || (s == S_DOOR) || (s == S_ALARM_ON);
  endfunction

  state_t          r_state;
  logic            r_click_pend;
  logic            r_door_pend;
  logic            r_alarm_q;
  logic            r_cancel_q;
  logic [DW-1:0]   r_dur;
  logic [TW-1:0]   r_tcnt;
  logic            r_tone;
  logic [3:0]      r_burst;
  logic            r_buzzer;
  logic            r_busy;
  logic [1:0]      r_src;
  logic            r_done;

  state_t          w_next;
  logic            w_retrig;
  logic            w_alarm_start;
  logic            w_done;
  logic [3:0]      w_burst_nxt;
  logic [DW-1:0]   w_dur_lim;
  logic            w_dur_end;
  logic [TW-1:0]   w_div_m1;
  logic            w_enter;
  logic [TW-1:0]   w_tcnt_nxt;
  logic            w_tone_nxt;
  logic            w_click_clr;
  logic            w_door_clr;
  logic [1:0]      w_src_nxt;

  assign w_dur_end = (r_dur == w_dur_lim);
  assign w_enter   = (w_next != r_state);

  // Per-state duration limit and tone half-period for the current source.
  always_comb begin
    w_dur_lim = {DW{1'b0}};
    w_div_m1  = {TW{1'b0}};
    case (r_state)
      S_CLICK: begin
        w_dur_lim = DW'(CLICK_T - 1);
        w_div_m1  = TW'(CLICK_DIV - 1);
      end
      S_DOOR: begin
        w_dur_lim = DW'(DOOR_T - 1);
        w_div_m1  = TW'(DOOR_DIV - 1);
      end
      S_ALARM_ON: begin
        w_dur_lim = DW'(ON_T - 1);
        w_div_m1  = TW'(ALARM_DIV - 1);
      end
      S_ALARM_OFF: begin
        w_dur_lim = DW'(OFF_T - 1);
        w_div_m1  = {TW{1'b0}};
      end
      default: begin
        w_dur_lim = {DW{1'b0}};
        w_div_m1  = {TW{1'b0}};
      end
    endcase
  end

  // Next-state, retrigger, burst count and alarm_done decision.
  always_comb begin
    w_next        = r_state;
    w_retrig      = 1'b0;
    w_alarm_start = 1'b0;
    w_done        = 1'b0;
    w_burst_nxt   = r_burst;
    case (r_state)
      S_IDLE: begin
        if (r_alarm_q) begin
          w_next        = S_ALARM_ON;
          w_alarm_start = 1'b1;
          w_burst_nxt   = 4'd0;
        end else if (r_door_pend) begin
          w_next = S_DOOR;
        end else if (r_click_pend) begin
          w_next = S_CLICK;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLICK, S_DOOR: begin
        if (r_alarm_q) begin
          w_next        = S_ALARM_ON;
          w_alarm_start = 1'b1;
          w_burst_nxt   = 4'd0;
        end else if ((r_state == S_CLICK) ? r_click_pend : r_door_pend) begin
          w_retrig = 1'b1;
        end else if (w_dur_end) begin
          w_next = S_IDLE;
        end else begin
          w_next = r_state;
        end
      end
      S_ALARM_ON: begin
        if (r_cancel_q) begin
          w_next      = S_IDLE;
          w_done      = 1'b1;
          w_burst_nxt = 4'd0;
        end else if (r_alarm_q) begin
          w_retrig      = 1'b1;
          w_alarm_start = 1'b1;
          w_burst_nxt   = 4'd0;
        end else if (w_dur_end) begin
          if (r_burst == 4'(ALARM_REPEATS - 1)) begin
            // Last burst: straight to IDLE, no trailing gap.
            w_next      = S_IDLE;
            w_done      = 1'b1;
            w_burst_nxt = 4'd0;
          end else begin
            w_next      = S_ALARM_OFF;
            w_burst_nxt = r_burst + 4'd1;
          end
        end else begin
          w_next = S_ALARM_ON;
        end
      end
      S_ALARM_OFF: begin
        if (r_cancel_q) begin
          w_next      = S_IDLE;
          w_done      = 1'b1;
          w_burst_nxt = 4'd0;
        end else if (r_alarm_q) begin
          w_next        = S_ALARM_ON;
          w_alarm_start = 1'b1;
          w_burst_nxt   = 4'd0;
        end else if (w_dur_end) begin
          w_next = S_ALARM_ON;
        end else begin
          w_next = S_ALARM_OFF;
        end
      end
      default: begin
        w_next      = S_IDLE;
        w_burst_nxt = 4'd0;
      end
    endcase
  end

  // Pending-flag clears: own state entered/retriggered, or any alarm start.
  always_comb begin
    w_click_clr = w_alarm_start || ((w_next == S_CLICK) && (w_enter || w_retrig));
    w_door_clr  = w_alarm_start || ((w_next == S_DOOR) && (w_enter || w_retrig));
  end

  // Tone divider: restarts low on state entry, keeps running on retrigger.
  always_comb begin
    w_tcnt_nxt = r_tcnt;
    w_tone_nxt = r_tone;
    if (w_enter) begin
      w_tcnt_nxt = {TW{1'b0}};
      w_tone_nxt = 1'b0;
    end else if (is_sounding(r_state)) begin
      if (r_tcnt == w_div_m1) begin
        w_tcnt_nxt = {TW{1'b0}};
        w_tone_nxt = ~r_tone;
      end else begin
        w_tcnt_nxt = r_tcnt + TW'(1);
        w_tone_nxt = r_tone;
      end
    end else begin
      w_tcnt_nxt = {TW{1'b0}};
      w_tone_nxt = 1'b0;
    end
  end

  // Source code reported for the state being entered.
  always_comb begin
    w_src_nxt = 2'd0;
    case (w_next)
      S_CLICK:     w_src_nxt = 2'd1;
      S_DOOR:      w_src_nxt = 2'd2;
      S_ALARM_ON:  w_src_nxt = 2'd3;
      S_ALARM_OFF: w_src_nxt = 2'd3;
      default:     w_src_nxt = 2'd0;
    endcase
  end

  // State, counters, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_click_pend <= 1'b0;
      r_door_pend  <= 1'b0;
      r_alarm_q    <= 1'b0;
      r_cancel_q   <= 1'b0;
      r_dur        <= {DW{1'b0}};
      r_tcnt       <= {TW{1'b0}};
      r_tone       <= 1'b0;
      r_burst      <= 4'd0;
      r_buzzer     <= 1'b0;
      r_busy       <= 1'b0;
      r_src        <= 2'd0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_click_pend <= w_click_clr ? 1'b0 : (r_click_pend | click_req);
      r_door_pend  <= w_door_clr ? 1'b0 : (r_door_pend | door_req);
      // A cancel in the same cycle as a request suppresses the request.
      r_alarm_q    <= alarm_req & ~alarm_cancel;
      r_cancel_q   <= alarm_cancel;
      if (w_enter || w_retrig || (w_next == S_IDLE)) begin
        r_dur <= {DW{1'b0}};
      end else begin
        r_dur <= r_dur + DW'(1);
      end
      r_tcnt       <= w_tcnt_nxt;
      r_tone       <= w_tone_nxt;
      r_burst      <= w_burst_nxt;
      r_buzzer     <= w_tone_nxt & is_sounding(w_next) & ~mute;
      r_busy       <= (w_next != S_IDLE);
      r_src        <= w_src_nxt;
      r_done       <= w_done;
    end
  end

  assign buzzer     = r_buzzer;
  assign busy       = r_busy;
  assign active_src = r_src;
  assign alarm_done = r_done;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler: each scenario pushes its expected
// per-cycle output trace onto a scoreboard, then drives the requests and
// pops/compares one entry per clock.
module tb_buzzer_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       click_req = 1'b0;
  logic       door_req = 1'b0;
  logic       alarm_req = 1'b0;
  logic       alarm_cancel = 1'b0;
  logic       mute = 1'b0;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_src;
  logic       alarm_done;

  typedef struct packed {
    logic       busy;
    logic [1:0] src;
    logic       buz;
    logic       done;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  string scen = "init";
  int    cidx = 0;

  buzzer_scheduler #(
    .TICKS_PER_MS(10), .CLICK_MS(5), .DOOR_MS(8), .ALARM_ON_MS(4),
    .ALARM_OFF_MS(3), .ALARM_REPEATS(2), .CLICK_DIV(2), .DOOR_DIV(4),
    .ALARM_DIV(1)
  ) dut (
    .clk(clk), .reset(reset), .click_req(click_req), .door_req(door_req),
    .alarm_req(alarm_req), .alarm_cancel(alarm_cancel), .mute(mute),
    .buzzer(buzzer), .busy(busy), .active_src(active_src),
    .alarm_done(alarm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s_%s_c%0d observed=%0h expected=%0h", scen, tag, cidx, obs, exp);
    end
  endtask

  // n cycles of source src; div=0 means tone silent, k0 = cycles since entry.
  task automatic push_n(input int n, input logic [1:0] src, input int div,
                        input int k0, input logic done);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.busy = (src != 2'd0);
      e.src  = src;
      e.buz  = (div > 0) ? ((((k0 + i) / div) % 2) == 1) : 1'b0;
      e.done = done;
      q.push_back(e);
    end
  endtask

  task automatic cyc(input logic c, input logic d, input logic a,
                     input logic x, input logic r);
    exp_t e;
    click_req = c; door_req = d; alarm_req = a; alarm_cancel = x; reset = r;
    @(posedge clk);
    #1;
    click_req = 1'b0; door_req = 1'b0; alarm_req = 1'b0;
    alarm_cancel = 1'b0; reset = 1'b0;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_scoreboard_empty_c%0d observed=0 expected=1", scen, cidx);
    end else begin
      e = q.pop_front();
      chk("busy", {3'b000, busy}, {3'b000, e.busy});
      chk("src", {2'b00, active_src}, {2'b00, e.src});
      chk("buzzer", {3'b000, buzzer}, {3'b000, e.buz});
      chk("done", {3'b000, alarm_done}, {3'b000, e.done});
    end
  endtask

  // Run n cycles; each *_at is the cycle whose edge samples that pulse (-1 = never).
  task automatic run(input int n, input int ca, input int cb, input int da,
                     input int aa, input int ab, input int ac, input int xa,
                     input int ra);
    for (int c = 0; c < n; c++) begin
      cidx = c;
      cyc(c == ca || c == cb, c == da, c == aa || c == ab || c == ac,
          c == xa, c == ra);
    end
  endtask

  initial begin
    // Reset: all outputs zero.
    scen = "reset";
    push_n(3, 2'd0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cidx = i;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Single click: CLICK cycles 1-50, tone period 4 starting low, IDLE at 51.
    scen = "click";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(50, 2'd1, 2, 0, 1'b0);
    push_n(2, 2'd0, 0, 0, 1'b0);
    run(53, 0, -1, -1, -1, -1, -1, -1, -1);

    // Alarm: ON 40, OFF 30, ON 40, done at cycle 111.
    scen = "alarm";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(40, 2'd3, 1, 0, 1'b0);
    push_n(30, 2'd3, 0, 0, 1'b0);
    push_n(40, 2'd3, 1, 0, 1'b0);
    push_n(1, 2'd0, 0, 0, 1'b1);
    push_n(1, 2'd0, 0, 0, 1'b0);
    run(113, -1, -1, -1, 0, -1, -1, -1, -1);

    // Preemption: click dropped when alarm arrives 10 cycles in.
    scen = "preempt";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(10, 2'd1, 2, 0, 1'b0);
    push_n(40, 2'd3, 1, 0, 1'b0);
    push_n(30, 2'd3, 0, 0, 1'b0);
    push_n(40, 2'd3, 1, 0, 1'b0);
    push_n(1, 2'd0, 0, 0, 1'b1);
    push_n(1, 2'd0, 0, 0, 1'b0);
    run(123, 0, -1, -1, 10, -1, -1, -1, -1);

    // Queueing: door requested mid-click plays after one IDLE cycle.
    scen = "queue";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(50, 2'd1, 2, 0, 1'b0);
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(80, 2'd2, 4, 0, 1'b0);
    push_n(2, 2'd0, 0, 0, 1'b0);
    run(134, 0, -1, 20, -1, -1, -1, -1, -1);

    // Cancel under mute: buzzer silent, IDLE and done at cycle 51.
    scen = "cancel_mute";
    mute = 1'b1;
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(40, 2'd3, 0, 0, 1'b0);
    push_n(10, 2'd3, 0, 0, 1'b0);
    push_n(1, 2'd0, 0, 0, 1'b1);
    push_n(1, 2'd0, 0, 0, 1'b0);
    run(53, -1, -1, -1, 0, -1, -1, 50, -1);
    mute = 1'b0;

    // Reset mid-door with a click pending: outputs 0, pending click lost.
    scen = "reset_door";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(20, 2'd2, 4, 0, 1'b0);
    push_n(6, 2'd0, 0, 0, 1'b0);
    run(27, 5, -1, 0, -1, -1, -1, -1, 21);

    // Click retrigger at 30: CLICK lasts until cycle 80, tone uninterrupted.
    scen = "retrig_click";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(80, 2'd1, 2, 0, 1'b0);
    push_n(2, 2'd0, 0, 0, 1'b0);
    run(83, 0, 30, -1, -1, -1, -1, -1, -1);

    // Alarm retrigger in ON at 20, then alarm+cancel together: cancel wins.
    scen = "retrig_alarm";
    push_n(1, 2'd0, 0, 0, 1'b0);
    push_n(60, 2'd3, 1, 0, 1'b0);
    push_n(30, 2'd3, 0, 0, 1'b0);
    push_n(10, 2'd3, 1, 0, 1'b0);
    push_n(1, 2'd0, 0, 0, 1'b1);
    push_n(1, 2'd0, 0, 0, 1'b0);
    run(103, -1, -1, -1, 0, 20, 100, 100, -1);

    scen = "end";
    cidx = 0;
    chk("scoreboard_left", q.size() > 0 ? 4'd1 : 4'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
